// File: rtl/stream_demux_1ton.sv
// -----------------------------------------------------------------------------
// stream_demux_1ton
//
// Registered 1-to-N stream demultiplexer. One valid/ready packet stream from a
// shared producer is routed, packet by packet, to one of N_OUT valid/ready
// consumers. The destination is taken from in_sel on the first beat of each
// packet and held until the beat carrying in_last. Packets whose first beat
// names a non-existent channel are swallowed whole and flagged on drop_pulse.
//
// A single hold register sits between input and outputs, so every accepted
// beat appears on the outputs exactly one cycle later and there is no
// combinational path from any input to out_valid/out_data/out_last.
//
// Handshake: a beat transfers on any rising clk edge where valid && ready are
// both high. Once out_valid[k] is raised it stays high, with out_data/out_last
// unchanged, until out_ready[k] is seen high; valid never waits on ready.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        input beat valid
//   in_ready   out  1        input beat accepted when in_valid && in_ready
//   in_data    in   DATA_W   input payload
//   in_last    in   1        final beat of packet
//   in_sel     in   SEL_W    destination channel, sampled on first beat only
//   out_valid  out  N_OUT    one-hot or zero, bit k = beat valid for channel k
//   out_ready  in   N_OUT    per-channel consumer ready
//   out_data   out  DATA_W   shared payload bus, qualified by out_valid
//   out_last   out  1        last flag of the held beat
//   drop_pulse out  1        1-cycle pulse after a first beat with illegal in_sel
//   dbg_state  out  2        packet-framing FSM state (IDLE/BUSY/DROP)
// -----------------------------------------------------------------------------
module stream_demux_1ton #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              drop_pulse,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // One extra bit so N_OUT == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0] N_OUT_C = (SEL_W + 1)'(N_OUT);

    logic [1:0]        state_q,     state_d;
    logic [SEL_W-1:0]  route_q,     route_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              hold_last_q, hold_last_d;
    logic [SEL_W-1:0]  hold_dest_q, hold_dest_d;
    logic              drop_q,      drop_d;

    logic first_beat;
    logic sel_illegal;
    logic discard;
    logic drain;
    logic accept;
    logic load;

    // Output decode works purely from registered state.
    always_comb begin
        out_valid = '0;
        for (int k = 0; k < N_OUT; k++) begin
            out_valid[k] = hold_full_q && (hold_dest_q == SEL_W'(k));
        end
    end

    assign out_data   = hold_data_q;
    assign out_last   = hold_last_q;
    assign drop_pulse = drop_q;
    assign dbg_state  = state_q;

    assign first_beat  = (state_q == ST_IDLE);
    assign sel_illegal = ({1'b0, in_sel} >= N_OUT_C);

    // Beats that will be thrown away never need the hold register, so they
    // are accepted even while a beat for some channel is stalled.
    assign discard = (state_q == ST_DROP) || (first_beat && sel_illegal);

    // Only the channel currently addressed by the hold register can drain it;
    // out_valid is zero for every other channel so their ready is ignored.
    assign drain    = |(out_valid & out_ready);
    assign in_ready = discard || !hold_full_q || drain;
    assign accept   = in_valid && in_ready;
    assign load     = accept && !discard;

    always_comb begin
        state_d     = state_q;
        route_d     = route_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        hold_dest_d = hold_dest_q;
        drop_d      = 1'b0;

        if (drain) begin
            hold_full_d = 1'b0;
        end

        // A load in the same cycle as a drain simply overwrites: no bubble.
        if (load) begin
            hold_full_d = 1'b1;
            hold_data_d = in_data;
            hold_last_d = in_last;
            hold_dest_d = first_beat ? in_sel : route_q;
        end

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    route_d = in_sel;
                    if (sel_illegal) begin
                        drop_d = 1'b1;
                        if (!in_last) begin
                            state_d = ST_DROP;
                        end
                    end else if (!in_last) begin
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY, ST_DROP: begin
                    if (in_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE && state_q != ST_BUSY && state_q != ST_DROP) begin
            // Unused encoding: recover to IDLE.
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            route_q     <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            hold_dest_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            route_q     <= route_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            hold_dest_q <= hold_dest_d;
            drop_q      <= drop_d;
        end
    end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_1ton
//
// Bench for stream_demux_1ton with N_OUT=3 and SEL_W=2, so in_sel=3 is an
// illegal destination. The reference model is a single ordered queue of
// {dest, last, data} for beats still owed to the outputs: because the design
// has one hold register, beats must leave in global acceptance order, and the
// head of the queue is exactly what the outputs must present. Packet framing
// (route of first beat, dropping of illegal packets) is tracked with plain
// flags derived from the beats as they are accepted.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_stream_demux_1ton;

    localparam int DATA_W = 8;
    localparam int N_OUT  = 3;
    localparam int SEL_W  = 2;
    localparam int QW     = SEL_W + 1 + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [SEL_W-1:0]  in_sel;
    logic [N_OUT-1:0]  out_valid;
    logic [N_OUT-1:0]  out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              drop_pulse;
    logic [1:0]        dbg_state;

    stream_demux_1ton #(
        .DATA_W(DATA_W),
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .drop_pulse(drop_pulse),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    int            checks = 0;
    int            errors = 0;
    int            accepted = 0;
    logic [QW-1:0] exp_q[$];
    logic          pkt_open = 1'b0;
    logic          pkt_drop = 1'b0;
    logic [SEL_W-1:0] pkt_dest = '0;
    logic          exp_drop = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SEL_W-1:0] head_dest();
        logic [QW-1:0] h;
        h = exp_q[0];
        return h[QW-1 -: SEL_W];
    endfunction

    // The input may be refused only when a real beat is still owed to a
    // channel that is not taking it this cycle and the incoming beat would
    // have to be stored.
    function automatic logic model_in_ready();
        logic discard;
        discard = pkt_open ? pkt_drop : (int'(in_sel) >= N_OUT);
        if (exp_q.size() == 0) return 1'b1;
        return discard || out_ready[head_dest()];
    endfunction

    task automatic model_accept();
        if (!pkt_open) begin
            pkt_dest = in_sel;
            pkt_drop = (int'(in_sel) >= N_OUT);
            exp_drop = pkt_drop;
        end
        if (!pkt_drop) exp_q.push_back({pkt_dest, in_last, in_data});
        pkt_open = !in_last;
        accepted++;
    endtask

    task automatic model_reset();
        exp_q.delete();
        pkt_open = 1'b0;
        pkt_drop = 1'b0;
        exp_drop = 1'b0;
    endtask

    // One clock cycle: check outputs against the model, record handshakes,
    // advance to the next falling edge.
    task automatic cycle(output logic acc);
        logic [QW-1:0]    head;
        logic [N_OUT-1:0] ev;
        #1;
        chk("drop_pulse", drop_pulse, exp_drop);
        chk("in_ready", in_ready, model_in_ready());
        if (exp_q.size() == 0) begin
            chk("out_valid_idle", out_valid, 0);
        end else begin
            head = exp_q[0];
            ev = '0;
            ev[head[QW-1 -: SEL_W]] = 1'b1;
            chk("out_valid", out_valid, ev);
            chk("out_data", out_data, head[DATA_W-1:0]);
            chk("out_last", out_last, head[DATA_W]);
        end
        acc = in_valid && in_ready;
        if (exp_q.size() != 0 && out_ready[head_dest()]) void'(exp_q.pop_front());
        exp_drop = 1'b0;
        if (acc) model_accept();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic send(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] d,
                        input logic last, output int waits);
        logic acc;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        in_last  = last;
        waits    = 0;
        acc      = 1'b0;
        while (!acc && waits < 50) begin
            cycle(acc);
            if (!acc) waits++;
        end
        if (!acc) chk("send_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int   w;
        int   cyc;
        int   target;
        logic acc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_sel    = '0;
        out_ready = '1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_in_ready", in_ready, 1);
        idle(2);

        // Reset in the middle of traffic: beat held for stalled ch1, an
        // illegal packet open (DROP) and drop_pulse high.
        out_ready = 3'b000;
        send(2'd1, 8'h11, 1'b1, w);
        send(2'd3, 8'hEE, 1'b0, w);
        chk("pre_rst_drop", drop_pulse, 1);
        chk("pre_rst_valid", out_valid, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data", out_data, 0);
        chk("async_rst_last", out_last, 0);
        chk("async_rst_drop", drop_pulse, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = '1;
        #1 chk("rel_in_ready", in_ready, 1);
        send(2'd0, 8'h22, 1'b1, w);   // must be treated as a fresh first beat
        idle(2);

        // 3-beat packet to channel 2, consumer always ready
        send(2'd2, 8'hA1, 1'b0, w);
        #1;
        chk("lat_valid", out_valid, 3'b100);
        chk("lat_data", out_data, 8'hA1);
        send(2'd2, 8'hA2, 1'b0, w);
        chk("a2_waits", w, 0);
        send(2'd2, 8'hA3, 1'b1, w);
        chk("a3_waits", w, 0);
        #1;
        chk("a3_last", out_last, 1);
        chk("a3_data", out_data, 8'hA3);
        idle(2);

        // Route held for the packet despite in_sel changes; next packet
        // follows back-to-back on a different channel
        send(2'd1, 8'hB1, 1'b0, w);
        send(2'd0, 8'hB2, 1'b0, w);
        send(2'd0, 8'hB3, 1'b1, w);
        send(2'd0, 8'hC1, 1'b1, w);
        chk("no_bubble", w, 0);
        idle(2);

        // Stall: channel 2 not ready with 0x55 held, next beat waiting
        out_ready = 3'b011;
        send(2'd2, 8'h55, 1'b1, w);
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 8'h66;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(acc);
            chk("stall_no_accept", acc, 0);
        end
        out_ready = '1;
        cycle(acc);
        chk("release_accept", acc, 1);
        in_valid = 1'b0;
        #1 chk("after_release_data", out_data, 8'h66);
        idle(2);

        // Illegal destination, 2-beat packet
        send(2'd3, 8'hD1, 1'b0, w);
        #1 chk("drop_seen", drop_pulse, 1);
        send(2'd0, 8'hD2, 1'b1, w);
        idle(2);
        chk("drop_q_empty", exp_q.size(), 0);

        // Random traffic with random back-pressure
        target = accepted + 10000;
        cyc    = 0;
        acc    = 1'b0;
        while (accepted < target && cyc < 60000) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = SEL_W'($urandom_range(0, 3));
                in_data  = DATA_W'($urandom);
                in_last  = ($urandom_range(0, 3) == 0);
            end
            out_ready = N_OUT'($urandom_range(0, 7));
            cycle(acc);
            cyc++;
        end
        chk("random_beats_done", accepted >= target, 1);

        // Drain and confirm nothing is lost
        in_valid  = 1'b0;
        out_ready = '1;
        idle(4);
        chk("final_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
